// File: rtl/mc_ctrl_if.sv
// Control-unit bus: instruction fields and memory / mul-div handshakes in,
// datapath strobes, selects and status out. The controller takes the master
// modport; the datapath side takes the slave modport.
interface mc_ctrl_if;
    logic [6:0] i_opcode;
    logic [6:0] i_funct7;
    logic       i_mem_ready;
    logic       i_md_done;

    logic       o_RegWrite;
    logic       o_MemWrite;
    logic       o_MemReq;
    logic       o_IRWrite;
    logic       o_AdrSrc;
    logic       o_PCUpdate;
    logic       o_Branch;
    logic [1:0] o_ResultSrc;
    logic [1:0] o_ALUSrcA;
    logic [1:0] o_ALUSrcB;
    logic [1:0] o_ALUOp;
    logic       o_md_start;
    logic       o_instr_done;
    logic       o_fault;
    logic [4:0] o_state;

    modport master (
        input  i_opcode, i_funct7, i_mem_ready, i_md_done,
        output o_RegWrite, o_MemWrite, o_MemReq, o_IRWrite, o_AdrSrc,
               o_PCUpdate, o_Branch, o_ResultSrc, o_ALUSrcA, o_ALUSrcB,
               o_ALUOp, o_md_start, o_instr_done, o_fault, o_state
    );

    modport slave (
        output i_opcode, i_funct7, i_mem_ready, i_md_done,
        input  o_RegWrite, o_MemWrite, o_MemReq, o_IRWrite, o_AdrSrc,
               o_PCUpdate, o_Branch, o_ResultSrc, o_ALUSrcA, o_ALUSrcB,
               o_ALUOp, o_md_start, o_instr_done, o_fault, o_state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control unit. Sequences fetch/decode/execute/memory/
// writeback over a shared-ALU datapath, with ready-based memory handshake,
// optional memory timeout and optional mul/div dispatch. Outputs decode
// from the registered state; fetch strobes are qualified by i_mem_ready.
module mc_ctrl_fsm #(
    parameter bit          EN_MULDIV    = 1'b0,
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter bit          TRAP_ILLEGAL = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    mc_ctrl_if.master  bus
);

    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,  S_FETCH   = 5'd1,  S_DECODE  = 5'd2,
        S_MEMADR   = 5'd3,  S_MEMREAD = 5'd4,  S_MEMWB   = 5'd5,
        S_MEMWRITE = 5'd6,  S_EXEC_R  = 5'd7,  S_EXEC_I  = 5'd8,
        S_ALUWB    = 5'd9,  S_JAL     = 5'd10, S_JALR    = 5'd11,
        S_BRANCH   = 5'd12, S_LUI     = 5'd13, S_AUIPC   = 5'd14,
        S_EXEC_MD  = 5'd15, S_MDWB    = 5'd16, S_FAULT   = 5'd17
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Counter must be at least one bit wide even when the timeout is disabled.
    localparam int unsigned CW    = (MEM_TIMEOUT > 32'd0) ? $clog2(MEM_TIMEOUT + 32'd1) : 32'd1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic          r_md_seen;
    logic          w_wait;
    logic          w_timeout;

    // A memory state is stalling when memory has not answered this cycle.
    assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE))
                       && !bus.i_mem_ready;
    // Ready in the limit cycle takes precedence, so only a stalled cycle can time out.
    assign w_timeout = (MEM_TIMEOUT != 32'd0) && w_wait && (r_wait_cnt == LIMIT);

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory wait counter, cleared on any state change; mul/div first-cycle tracker.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wait_cnt <= {CW{1'b0}};
            r_md_seen  <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_wait_cnt <= {CW{1'b0}};
            end else if (w_wait) begin
                r_wait_cnt <= r_wait_cnt + CW'(1'b1);
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
            r_md_seen <= (r_state == S_EXEC_MD);
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (bus.i_mem_ready)  w_state_nxt = S_DECODE;
                else if (w_timeout)   w_state_nxt = S_FAULT;
                else                  w_state_nxt = S_FETCH;
            end
            S_DECODE: begin
                case (bus.i_opcode)
                    OP_LOAD, OP_STORE: w_state_nxt = S_MEMADR;
                    OP_RTYPE: begin
                        if (EN_MULDIV && (bus.i_funct7 == F7_MULDIV)) w_state_nxt = S_EXEC_MD;
                        else                                           w_state_nxt = S_EXEC_R;
                    end
                    OP_ITYPE:  w_state_nxt = S_EXEC_I;
                    OP_JAL:    w_state_nxt = S_JAL;
                    OP_JALR:   w_state_nxt = S_JALR;
                    OP_BRANCH: w_state_nxt = S_BRANCH;
                    OP_LUI:    w_state_nxt = S_LUI;
                    OP_AUIPC:  w_state_nxt = S_AUIPC;
                    default:   w_state_nxt = TRAP_ILLEGAL ? S_FAULT : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.i_opcode == OP_LOAD) w_state_nxt = S_MEMREAD;
                else                         w_state_nxt = S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (bus.i_mem_ready)  w_state_nxt = S_MEMWB;
                else if (w_timeout)   w_state_nxt = S_FAULT;
                else                  w_state_nxt = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (bus.i_mem_ready)  w_state_nxt = S_FETCH;
                else if (w_timeout)   w_state_nxt = S_FAULT;
                else                  w_state_nxt = S_MEMWRITE;
            end
            S_MEMWB:    w_state_nxt = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: w_state_nxt = S_ALUWB;
            S_ALUWB:    w_state_nxt = S_FETCH;
            S_JALR:     w_state_nxt = S_JAL;
            S_JAL:      w_state_nxt = S_ALUWB;
            S_BRANCH:   w_state_nxt = S_FETCH;
            S_EXEC_MD: begin
                if (bus.i_md_done) w_state_nxt = S_MDWB;
                else               w_state_nxt = S_EXEC_MD;
            end
            S_MDWB:     w_state_nxt = S_FETCH;
            S_FAULT:    w_state_nxt = S_FAULT;
            default:    w_state_nxt = S_FAULT;
        endcase
    end

    // Datapath strobe/select decode from the registered state.
    always_comb begin
        bus.o_RegWrite  = 1'b0;
        bus.o_MemWrite  = 1'b0;
        bus.o_MemReq    = 1'b0;
        bus.o_IRWrite   = 1'b0;
        bus.o_AdrSrc    = 1'b0;
        bus.o_PCUpdate  = 1'b0;
        bus.o_Branch    = 1'b0;
        bus.o_ResultSrc = 2'b00;
        bus.o_ALUSrcA   = 2'b00;
        bus.o_ALUSrcB   = 2'b00;
        bus.o_ALUOp     = 2'b00;
        bus.o_md_start  = 1'b0;
        bus.o_fault     = 1'b0;
        bus.o_state     = r_state;
        case (r_state)
            S_FETCH: begin
                bus.o_MemReq    = 1'b1;
                bus.o_IRWrite   = bus.i_mem_ready;
                bus.o_PCUpdate  = bus.i_mem_ready;
                bus.o_ALUSrcB   = 2'b10;
                bus.o_ResultSrc = 2'b10;
            end
            S_DECODE, S_AUIPC: begin
                bus.o_ALUSrcA = 2'b01;
                bus.o_ALUSrcB = 2'b01;
            end
            S_MEMADR, S_JALR: begin
                bus.o_ALUSrcA = 2'b10;
                bus.o_ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                bus.o_MemReq = 1'b1;
                bus.o_AdrSrc = 1'b1;
            end
            S_MEMWRITE: begin
                bus.o_MemReq   = 1'b1;
                bus.o_MemWrite = 1'b1;
                bus.o_AdrSrc   = 1'b1;
            end
            S_MEMWB: begin
                bus.o_ResultSrc = 2'b01;
                bus.o_RegWrite  = 1'b1;
            end
            S_EXEC_R: begin
                bus.o_ALUSrcA = 2'b10;
                bus.o_ALUOp   = 2'b10;
            end
            S_EXEC_I: begin
                bus.o_ALUSrcA = 2'b10;
                bus.o_ALUSrcB = 2'b01;
                bus.o_ALUOp   = 2'b10;
            end
            S_LUI: begin
                bus.o_ALUSrcA = 2'b11;
                bus.o_ALUSrcB = 2'b01;
            end
            S_ALUWB:   bus.o_RegWrite = 1'b1;
            S_JAL: begin
                bus.o_ALUSrcA  = 2'b01;
                bus.o_ALUSrcB  = 2'b10;
                bus.o_PCUpdate = 1'b1;
            end
            S_BRANCH: begin
                bus.o_ALUSrcA = 2'b10;
                bus.o_ALUOp   = 2'b01;
                bus.o_Branch  = 1'b1;
            end
            S_EXEC_MD: bus.o_md_start = !r_md_seen;
            S_MDWB: begin
                bus.o_ResultSrc = 2'b11;
                bus.o_RegWrite  = 1'b1;
            end
            S_FAULT:   bus.o_fault = 1'b1;
            default:   bus.o_fault = 1'b0;
        endcase
    end

    // Retire pulse: leaving an instruction state for FETCH (a FETCH stall is not a retire).
    always_comb begin
        if ((w_state_nxt == S_FETCH) && (r_state != S_IDLE) &&
            (r_state != S_FAULT) && (r_state != S_FETCH)) begin
            bus.o_instr_done = 1'b1;
        end else begin
            bus.o_instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm. Instance A uses default parameters;
// instance B enables mul/div, a 4-cycle memory timeout and NOP on illegal.
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    logic rstn_a;
    logic rstn_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    mc_ctrl_if if_a ();
    mc_ctrl_if if_b ();

    mc_ctrl_fsm dut_a (.i_clk(clk), .i_rstn(rstn_a), .bus(if_a));
    mc_ctrl_fsm #(.EN_MULDIV(1'b1), .MEM_TIMEOUT(4), .TRAP_ILLEGAL(1'b0))
        dut_b (.i_clk(clk), .i_rstn(rstn_b), .bus(if_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        if_a.i_opcode = 7'b0110011; if_a.i_funct7 = 7'd0; if_a.i_mem_ready = 1'b1; if_a.i_md_done = 1'b0;
        if_b.i_opcode = 7'b0110011; if_b.i_funct7 = 7'b0000001; if_b.i_mem_ready = 1'b1; if_b.i_md_done = 1'b0;
        #1;
        // Reset state: IDLE with every output low.
        chk("rst_state", 32'(if_a.o_state), 32'd0);
        chk("rst_outs", 32'({if_a.o_RegWrite, if_a.o_MemWrite, if_a.o_MemReq, if_a.o_IRWrite,
                             if_a.o_AdrSrc, if_a.o_PCUpdate, if_a.o_Branch, if_a.o_ResultSrc,
                             if_a.o_ALUSrcA, if_a.o_ALUSrcB, if_a.o_ALUOp, if_a.o_md_start,
                             if_a.o_instr_done, if_a.o_fault}), 32'd0);

        // ---------------- Instance A: R-type ----------------
        @(negedge clk);
        rstn_a = 1'b1;
        #1;
        chk("r_idle", 32'(if_a.o_state), 32'd0);
        tick();
        chk("r_fetch", 32'(if_a.o_state), 32'd1);
        chk("r_fetch_req", 32'({if_a.o_MemReq, if_a.o_IRWrite, if_a.o_PCUpdate, if_a.o_AdrSrc}), 32'b1110);
        chk("r_fetch_sel", 32'({if_a.o_ResultSrc, if_a.o_ALUSrcA, if_a.o_ALUSrcB}), 32'b10_00_10);
        tick();
        chk("r_decode", 32'(if_a.o_state), 32'd2);
        chk("r_decode_sel", 32'({if_a.o_ALUSrcA, if_a.o_ALUSrcB, if_a.o_ALUOp}), 32'b01_01_00);
        tick();
        chk("r_exec", 32'(if_a.o_state), 32'd7);
        chk("r_exec_sel", 32'({if_a.o_ALUSrcA, if_a.o_ALUSrcB, if_a.o_ALUOp}), 32'b10_00_10);
        chk("r_exec_rw", 32'({if_a.o_RegWrite, if_a.o_instr_done}), 32'b00);
        tick();
        chk("r_aluwb", 32'(if_a.o_state), 32'd9);
        chk("r_aluwb_rw", 32'({if_a.o_RegWrite, if_a.o_instr_done, if_a.o_ResultSrc}), 32'b1_1_00);
        // ---------------- Instance A: load with 3 wait cycles ----------------
        if_a.i_opcode = 7'b0000011;
        tick();
        chk("ld_fetch", 32'(if_a.o_state), 32'd1);
        chk("r_fetch_rw", 32'(if_a.o_RegWrite), 32'd0);
        tick();
        chk("ld_decode", 32'(if_a.o_state), 32'd2);
        tick();
        chk("ld_memadr", 32'(if_a.o_state), 32'd3);
        chk("ld_memadr_sel", 32'({if_a.o_ALUSrcA, if_a.o_ALUSrcB, if_a.o_ALUOp}), 32'b10_01_00);
        if_a.i_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld_memread", 32'(if_a.o_state), 32'd4);
            chk("ld_memread_req", 32'({if_a.o_MemReq, if_a.o_AdrSrc, if_a.o_MemWrite, if_a.o_ResultSrc}), 32'b1_1_0_00);
        end
        tick();
        if_a.i_mem_ready = 1'b1;
        #1;
        chk("ld_memread_rdy", 32'(if_a.o_state), 32'd4);
        tick();
        chk("ld_memwb", 32'(if_a.o_state), 32'd5);
        chk("ld_memwb_out", 32'({if_a.o_RegWrite, if_a.o_instr_done, if_a.o_ResultSrc}), 32'b1_1_01);
        // ---------------- Instance A: JALR ----------------
        if_a.i_opcode = 7'b1100111;
        tick();
        chk("jalr_fetch", 32'(if_a.o_state), 32'd1);
        tick();
        chk("jalr_decode", 32'(if_a.o_state), 32'd2);
        tick();
        chk("jalr_state", 32'(if_a.o_state), 32'd11);
        chk("jalr_sel", 32'({if_a.o_ALUSrcA, if_a.o_ALUSrcB, if_a.o_ALUOp}), 32'b10_01_00);
        tick();
        chk("jal_state", 32'(if_a.o_state), 32'd10);
        chk("jal_out", 32'({if_a.o_PCUpdate, if_a.o_ALUSrcA, if_a.o_ALUSrcB, if_a.o_ResultSrc, if_a.o_RegWrite}), 32'b1_01_10_00_0);
        tick();
        chk("jal_aluwb", 32'(if_a.o_state), 32'd9);
        // ---------------- Instance A: branch ----------------
        if_a.i_opcode = 7'b1100011;
        tick();
        tick();
        tick();
        chk("br_state", 32'(if_a.o_state), 32'd12);
        chk("br_out", 32'({if_a.o_Branch, if_a.o_ALUOp, if_a.o_ALUSrcA, if_a.o_ALUSrcB, if_a.o_instr_done, if_a.o_PCUpdate}), 32'b1_01_10_00_1_0);
        // ---------------- Instance A: store ----------------
        if_a.i_opcode = 7'b0100011;
        tick();
        chk("st_fetch", 32'(if_a.o_state), 32'd1);
        tick();
        tick();
        chk("st_memadr", 32'(if_a.o_state), 32'd3);
        tick();
        chk("st_memwrite", 32'(if_a.o_state), 32'd6);
        chk("st_out", 32'({if_a.o_MemReq, if_a.o_MemWrite, if_a.o_AdrSrc, if_a.o_instr_done, if_a.o_RegWrite}), 32'b1_1_1_1_0);
        // ---------------- Instance A: mul/div opcode without EN_MULDIV ----------------
        if_a.i_opcode = 7'b0110011;
        if_a.i_funct7 = 7'b0000001;
        tick();
        tick();
        tick();
        chk("nomd_exec_r", 32'(if_a.o_state), 32'd7);
        chk("nomd_start", 32'(if_a.o_md_start), 32'd0);
        tick();
        chk("nomd_aluwb", 32'(if_a.o_state), 32'd9);
        // ---------------- Instance A: illegal opcode traps ----------------
        if_a.i_opcode = 7'b1111111;
        tick();
        tick();
        tick();
        chk("ill_fault", 32'(if_a.o_state), 32'd17);
        chk("ill_fault_out", 32'({if_a.o_fault, if_a.o_MemReq, if_a.o_RegWrite, if_a.o_IRWrite, if_a.o_instr_done}), 32'b1_0_0_0_0);
        tick();
        chk("ill_sticky", 32'({if_a.o_state, if_a.o_fault}), 32'({5'd17, 1'b1}));
        #1;
        rstn_a = 1'b0;
        #1;
        chk("ill_rst_state", 32'(if_a.o_state), 32'd0);
        chk("ill_rst_fault", 32'(if_a.o_fault), 32'd0);

        // ---------------- Instance B: mul/div ----------------
        @(negedge clk);
        rstn_b = 1'b1;
        tick();
        chk("md_fetch", 32'(if_b.o_state), 32'd1);
        tick();
        chk("md_decode", 32'(if_b.o_state), 32'd2);
        tick();
        chk("md_exec", 32'(if_b.o_state), 32'd15);
        chk("md_start1", 32'(if_b.o_md_start), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("md_hold", 32'({if_b.o_state, if_b.o_md_start}), 32'({5'd15, 1'b0}));
        end
        tick();
        if_b.i_md_done = 1'b1;
        #1;
        chk("md_done_cyc", 32'({if_b.o_state, if_b.o_md_start}), 32'({5'd15, 1'b0}));
        tick();
        if_b.i_md_done = 1'b0;
        chk("md_mdwb", 32'(if_b.o_state), 32'd16);
        chk("md_mdwb_out", 32'({if_b.o_ResultSrc, if_b.o_RegWrite, if_b.o_instr_done}), 32'b11_1_1);
        // ---------------- Instance B: illegal opcode as NOP ----------------
        if_b.i_opcode = 7'b1111111;
        tick();
        tick();
        chk("nop_decode", 32'(if_b.o_state), 32'd2);
        chk("nop_done", 32'({if_b.o_instr_done, if_b.o_RegWrite, if_b.o_fault}), 32'b1_0_0);
        tick();
        chk("nop_fetch", 32'(if_b.o_state), 32'd1);
        // ---------------- Instance B: ready in the limit cycle wins ----------------
        if_b.i_opcode = 7'b0110111;
        if_b.i_mem_ready = 1'b0;
        #1;
        chk("win_irw", 32'({if_b.o_IRWrite, if_b.o_PCUpdate, if_b.o_MemReq}), 32'b0_0_1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("win_wait", 32'(if_b.o_state), 32'd1);
        end
        if_b.i_mem_ready = 1'b1;
        tick();
        chk("win_decode", 32'({if_b.o_state, if_b.o_fault}), 32'({5'd2, 1'b0}));
        tick();
        chk("lui_state", 32'(if_b.o_state), 32'd13);
        chk("lui_sel", 32'({if_b.o_ALUSrcA, if_b.o_ALUSrcB, if_b.o_ALUOp}), 32'b11_01_00);
        tick();
        chk("lui_aluwb", 32'(if_b.o_state), 32'd9);
        tick();
        // ---------------- Instance B: fetch timeout ----------------
        if_b.i_mem_ready = 1'b0;
        #1;
        chk("to_fetch1", 32'(if_b.o_state), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_fetch_n", 32'({if_b.o_state, if_b.o_fault}), 32'({5'd1, 1'b0}));
        end
        tick();
        chk("to_fault", 32'({if_b.o_state, if_b.o_fault, if_b.o_MemReq}), 32'({5'd17, 1'b1, 1'b0}));
        if_b.i_mem_ready = 1'b1;
        tick();
        chk("to_sticky", 32'({if_b.o_state, if_b.o_fault}), 32'({5'd17, 1'b1}));
        rstn_b = 1'b0;
        #1;
        chk("to_rst", 32'({if_b.o_state, if_b.o_fault}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
